// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-granular round-robin arbiter merging N channels onto one FIFO write port
// Optional stall watchdog built when FIFO_ARB_WATCHDOG_EN is defined.
module fifo_wr_arbiter #(
    parameter int C_WIDTH    = 32,
    parameter int C_NUM_CHNL = 4,
    parameter int C_TIMEOUT  = 256
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [C_NUM_CHNL-1:0]         CHNL_VALID,
    input  logic [C_NUM_CHNL*C_WIDTH-1:0] CHNL_DATA,
    input  logic [C_NUM_CHNL-1:0]         CHNL_LAST,
    output logic [C_NUM_CHNL-1:0]         CHNL_READY,
    output logic [C_NUM_CHNL-1:0]         GRANT,
    output logic [C_WIDTH-1:0]            WR_DATA,
    output logic                          WR_EN,
    input  logic                          WR_FULL,
    output logic                          TIMEOUT
);
    localparam int IW = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [C_NUM_CHNL-1:0] grant_q, grant_d;
    logic [IW-1:0]         cur_q, cur_d;
    logic [IW-1:0]         last_q, last_d;

    logic                  busy;
    logic                  valid_g;
    logic                  last_g;
    logic                  xfer;
    logic                  wd_hit;
    logic                  release_pkt;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         cand;
    logic [C_NUM_CHNL-1:0] pick_oh;

    // Search starts one past the previous owner so every channel gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= C_NUM_CHNL; k++) begin
            cand = IW'((int'(last_q) + k) % C_NUM_CHNL);
            if (!pick_found && CHNL_VALID[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_oh = C_NUM_CHNL'(1) << pick_idx;

    assign busy    = (state_q == S_BUSY);
    assign valid_g = |(CHNL_VALID & grant_q);
    assign last_g  = |(CHNL_LAST & grant_q);
    assign xfer    = busy & valid_g & ~WR_FULL;

    // AND-OR mux: an all-zero grant naturally yields zero write data.
    always_comb begin
        WR_DATA = '0;
        for (int i = 0; i < C_NUM_CHNL; i++) begin
            WR_DATA = WR_DATA | (CHNL_DATA[i*C_WIDTH +: C_WIDTH] & {C_WIDTH{grant_q[i]}});
        end
    end

    assign CHNL_READY = busy ? (grant_q & {C_NUM_CHNL{~WR_FULL}}) : '0;
    assign WR_EN      = xfer;
    assign GRANT      = grant_q;

`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int CW = 16;

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    // Only cycles where the owner has nothing to offer count as stalls.
    assign wd_hit = busy && !valid_g && (wd_cnt_q == CW'(C_TIMEOUT - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (!busy || valid_g || wd_hit) begin
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign TIMEOUT = wd_hit;
`else
    logic [15:0] timeout_unused;
    assign timeout_unused = 16'(C_TIMEOUT);
    assign wd_hit         = 1'b0;
    assign TIMEOUT        = 1'b0;
`endif

    assign release_pkt = (xfer && last_g) || wd_hit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cur_d   = cur_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_BUSY;
                    grant_d = pick_oh;
                    cur_d   = pick_idx;
                end
            end
            default: begin
                if (release_pkt) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = cur_q;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            cur_q   <= '0;
            last_q  <= IW'(C_NUM_CHNL - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

endmodule
